// File: rtl/pll_phase_ctrl_if.sv
// Phase-step request channel between a requester and pll_phase_ctrl.
// The master issues requests; the slave (controller) reports progress.
interface pll_phase_ctrl_if #(
    parameter int unsigned STEP_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_sel;
    logic              req_dir;
    logic [STEP_W-1:0] req_steps;
    logic              done;
    logic              err;
    logic              busy;

    modport master (
        output req_valid, req_sel, req_dir, req_steps,
        input  req_ready, done, err, busy
    );

    modport slave (
        input  req_valid, req_sel, req_dir, req_steps,
        output req_ready, done, err, busy
    );
endinterface

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL controller: qualifies LOCK into a system reset and sequences
// dynamic phase steps. Clocked from the PLL reference so it runs while unlocked.
module pll_phase_ctrl #(
    parameter int unsigned LOCK_STABLE = 1024,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned STEP_W      = 6
) (
    input  logic             CLK_IN1,
    input  logic             RESET,
    input  logic             LOCKED,
    pll_phase_ctrl_if.slave  req,
    output logic             locked_sync,
    output logic             sys_reset,
    output logic [1:0]       PHASESEL,
    output logic             PHASEDIR,
    output logic             PHASESTEP,
    output logic             PHASELOADREG
);
    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] HOLD      = 3'd1;
    localparam logic [2:0] READY     = 3'd2;
    localparam logic [2:0] SETUP     = 3'd3;
    localparam logic [2:0] PULSE     = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;

    localparam int unsigned HOLD_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned PH_MAX = (SETUP_CYC > PULSE_CYC)
        ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
        : ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
    localparam int unsigned PH_W = $clog2(PH_MAX + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LOCK_STABLE - 1);
    localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0]   PULSE_LAST = PH_W'(PULSE_CYC - 1);
    localparam logic [PH_W-1:0]   GAP_LAST   = PH_W'(GAP_CYC - 1);

    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [1:0]        sel_q, sel_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              sys_reset_q, sys_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    assign locked_sync   = sync2_q;
    // Ready must drop in the very cycle lock is lost, so it is not registered.
    assign req.req_ready = (state_q == READY) && locked_sync;
    assign req.done      = done_q;
    assign req.err       = err_q;
    assign req.busy      = busy_q;
    assign sys_reset     = sys_reset_q;
    assign PHASESEL      = sel_q;
    assign PHASEDIR      = dir_q;
    assign PHASESTEP     = step_q;
    assign PHASELOADREG  = 1'b1;

    always_comb begin
        sync1_d    = LOCKED;
        sync2_d    = sync1_q;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ph_cnt_d   = ph_cnt_q;
        rem_d      = rem_q;
        sel_d      = sel_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                hold_cnt_d = '0;
                if (locked_sync) state_d = HOLD;
            end
            HOLD: begin
                if (!locked_sync) begin
                    state_d    = WAIT_LOCK;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = READY;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            READY: begin
                if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                end else if (req.req_valid) begin
                    sel_d    = req.req_sel;
                    dir_d    = req.req_dir;
                    rem_d    = req.req_steps;
                    ph_cnt_d = '0;
                    if (req.req_steps == '0) done_d = 1'b1;
                    else                     state_d = SETUP;
                end
            end
            SETUP, PULSE, GAP: begin
                if (!locked_sync) begin
                    state_d  = WAIT_LOCK;
                    err_d    = 1'b1;
                    rem_d    = '0;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                    if (state_q == SETUP && ph_cnt_q == SETUP_LAST) begin
                        state_d  = PULSE;
                        ph_cnt_d = '0;
                    end else if (state_q == PULSE && ph_cnt_q == PULSE_LAST) begin
                        state_d  = GAP;
                        ph_cnt_d = '0;
                        rem_d    = rem_q - 1'b1;
                    end else if (state_q == GAP && ph_cnt_q == GAP_LAST) begin
                        ph_cnt_d = '0;
                        if (rem_q != '0) begin
                            state_d = PULSE;
                        end else begin
                            state_d = READY;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        // Outputs are registered decodes of the next state to keep PLL pins glitch-free.
        step_d      = (state_d != PULSE);
        busy_d      = (state_d == SETUP) || (state_d == PULSE) || (state_d == GAP);
        sys_reset_d = (state_d == WAIT_LOCK) || (state_d == HOLD);
    end

    always_ff @(posedge CLK_IN1 or posedge RESET) begin
        if (RESET) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= WAIT_LOCK;
            hold_cnt_q  <= '0;
            ph_cnt_q    <= '0;
            rem_q       <= '0;
            sel_q       <= 2'd0;
            dir_q       <= 1'b0;
            step_q      <= 1'b1;
            sys_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            ph_cnt_q    <= ph_cnt_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            sys_reset_q <= sys_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: lock qualification, phase-step sequencing,
// lock loss and asynchronous reset, with hand-computed expected values.
module tb_pll_phase_ctrl;
    logic       CLK_IN1 = 1'b0;
    logic       RESET;
    logic       LOCKED;
    logic       locked_sync;
    logic       sys_reset;
    logic [1:0] PHASESEL;
    logic       PHASEDIR;
    logic       PHASESTEP;
    logic       PHASELOADREG;

    int checks = 0;
    int errors = 0;

    pll_phase_ctrl_if #(.STEP_W(6)) rif ();

    pll_phase_ctrl dut (
        .CLK_IN1      (CLK_IN1),
        .RESET        (RESET),
        .LOCKED       (LOCKED),
        .req          (rif),
        .locked_sync  (locked_sync),
        .sys_reset    (sys_reset),
        .PHASESEL     (PHASESEL),
        .PHASEDIR     (PHASEDIR),
        .PHASESTEP    (PHASESTEP),
        .PHASELOADREG (PHASELOADREG)
    );

    always #5 CLK_IN1 = ~CLK_IN1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK_IN1);
    endtask

    // Count ticks until req_ready rises (bounded); used after any relock.
    task automatic wait_ready(output int n, output int ev);
        n  = 0;
        ev = 0;
        do begin
            tick();
            n++;
            if (rif.done || rif.err || PHASESTEP !== 1'b1) ev++;
        end while (rif.req_ready !== 1'b1 && n < 3000);
    endtask

    // Issue one request and record outputs for nk ticks, k=0 being the tick after acceptance.
    task automatic send_req(input logic [1:0] sel, input logic dir, input logic [5:0] steps,
                            input int nk, input int drop_at,
                            output logic rdy0, output logic [63:0] ps_pat,
                            output logic [63:0] done_pat, output logic [63:0] busy_pat,
                            output logic [63:0] err_pat, output logic [63:0] rdy_pat,
                            output int sel_bad);
        ps_pat = '0; done_pat = '0; busy_pat = '0; err_pat = '0; rdy_pat = '0; sel_bad = 0;
        rdy0 = rif.req_ready;
        rif.req_valid = 1'b1;
        rif.req_sel   = sel;
        rif.req_dir   = dir;
        rif.req_steps = steps;
        for (int k = 0; k < nk; k++) begin
            tick();
            ps_pat[k]   = PHASESTEP;
            done_pat[k] = rif.done;
            busy_pat[k] = rif.busy;
            err_pat[k]  = rif.err;
            rdy_pat[k]  = rif.req_ready;
            if (rif.busy && (PHASESEL !== sel || PHASEDIR !== dir)) sel_bad++;
            if (k == 0) rif.req_valid = 1'b0;
            if (k == drop_at) LOCKED = 1'b0;
        end
    endtask

    initial begin
        logic        rdy0;
        logic [63:0] ps, dn, bz, er, rd;
        int          sb, n, ev, first_ls, bad;

        RESET = 1'b1;
        LOCKED = 1'b1;
        rif.req_valid = 1'b0;
        rif.req_sel = 2'd0;
        rif.req_dir = 1'b0;
        rif.req_steps = '0;
        repeat (3) tick();

        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_locked_sync", locked_sync, 0);
        chk("rst_ready", rif.req_ready, 0);
        chk("rst_busy_done_err", {rif.busy, rif.done, rif.err}, 0);
        chk("rst_phase_pins", {PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG}, 5'b00011);

        // Lock qualification from release: 2 sync edges, 1 entry edge, 1024 hold cycles.
        RESET = 1'b0;
        n = 0; bad = 0; first_ls = 0;
        do begin
            tick();
            n++;
            if (locked_sync && first_ls == 0) first_ls = n;
            if (PHASESTEP !== 1'b1 || PHASELOADREG !== 1'b1) bad++;
        end while (sys_reset !== 1'b0 && n < 3000);
        chk("sync_latency", first_ls, 2);
        chk("release_latency", n, 1027);
        chk("idle_pins_during_hold", bad, 0);
        chk("ready_after_release", rif.req_ready, 1);

        // One-cycle lock glitch at hold count 500 restarts the qualification.
        RESET = 1'b1;
        #1 RESET = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 503) LOCKED = 1'b0;
            if (n == 504) LOCKED = 1'b1;
            if (n == 505) chk("glitch_seen_sync", locked_sync, 0);
            if (n == 1030) chk("glitch_still_reset", sys_reset, 1);
        end while (sys_reset !== 1'b0 && n < 3000);
        chk("glitch_release_latency", n, 1531);

        // sel=2 dir=1 steps=3: pulses low on k=2-5,10-13,18-21, done at k=26.
        send_req(2'd2, 1'b1, 6'd3, 28, -1, rdy0, ps, dn, bz, er, rd, sb);
        chk("req3_ready_before", rdy0, 1);
        chk("req3_phasestep", ps, 64'hFC3C3C3);
        chk("req3_done", dn, 64'h4000000);
        chk("req3_busy", bz, 64'h3FFFFFF);
        chk("req3_ready", rd, 64'hC000000);
        chk("req3_err", er, 0);
        chk("req3_sel_dir_stable", sb, 0);
        chk("req3_sel_dir_kept", {PHASESEL, PHASEDIR}, 3'b101);

        // Zero steps: done on the first tick, no pin activity, never busy.
        send_req(2'd1, 1'b0, 6'd0, 4, -1, rdy0, ps, dn, bz, er, rd, sb);
        chk("zero_done", dn, 64'h1);
        chk("zero_phasestep", ps, 64'hF);
        chk("zero_busy", bz, 0);
        chk("zero_ready", rd, 64'hF);

        // Lock loss in the second pulse of a 5-step request; abort visible at k=13.
        send_req(2'd3, 1'b0, 6'd5, 20, 10, rdy0, ps, dn, bz, er, rd, sb);
        chk("loss_phasestep", ps, 64'hFE3C3);
        chk("loss_err", er, 64'h02000);
        chk("loss_done", dn, 0);
        chk("loss_busy", bz, 64'h01FFF);
        chk("loss_ready", rd, 0);
        chk("loss_sys_reset", sys_reset, 1);
        LOCKED = 1'b1;
        wait_ready(n, ev);
        chk("loss_relock_latency", n, 1027);
        chk("loss_no_events", ev, 0);

        // Asynchronous reset in the first pulse of a 2-step request.
        send_req(2'd2, 1'b0, 6'd2, 4, -1, rdy0, ps, dn, bz, er, rd, sb);
        chk("mid_pulse_low", PHASESTEP, 0);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_phasestep", PHASESTEP, 1);
        chk("async_rst_sys_reset", sys_reset, 1);
        chk("async_rst_busy", rif.busy, 0);
        RESET = 1'b0;
        wait_ready(n, ev);
        chk("rst_relock_latency", n, 1027);

        // Back-to-back: the second request is driven on the done tick of the first.
        send_req(2'd1, 1'b0, 6'd1, 11, -1, rdy0, ps, dn, bz, er, rd, sb);
        chk("b2b_first_ready", rdy0, 1);
        chk("b2b_first_phasestep", ps, 64'h7C3);
        chk("b2b_first_done", dn, 64'h400);
        send_req(2'd0, 1'b1, 6'd0, 2, -1, rdy0, ps, dn, bz, er, rd, sb);
        chk("b2b_second_ready", rdy0, 1);
        chk("b2b_second_done", dn, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
- Controller for the ECP5 EHXPLLL clock generator used for the ELF system clock.
- Qualifies the PLL LOCK output and produces the synchronous system reset for the design.
- Sequences dynamic phase-step requests onto the PLL PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG pins.
- Runs on the 25 MHz PLL input clock, never on a PLL output, so it keeps running while the PLL is unlocked.

Parameters:
- LOCK_STABLE, 1024: consecutive cycles synced lock must stay high before sys_reset releases.
- SETUP_CYC, 2: cycles PHASESEL/PHASEDIR are driven before the first PHASESTEP pulse.
- PULSE_CYC, 4: cycles PHASESTEP is held low per step.
- GAP_CYC, 4: cycles PHASESTEP is held high after each pulse.
- STEP_W, 6: width of the step-count field.

Ports:
- CLK_IN1  in  1  25 MHz reference clock; also feeds the PLL CLKI.
- RESET  in  1  asynchronous, active-high reset.
- LOCKED  in  1  PLL LOCK, asynchronous to CLK_IN1.
- req_valid  in  1  phase-step request valid.
- req_ready  out  1  controller accepts a request this cycle.
- req_sel  in  2  output select (PHASESEL value).
- req_dir  in  1  step direction (PHASEDIR value).
- req_steps  in  STEP_W  number of steps.
- done  out  1  one-cycle pulse: request completed.
- err  out  1  one-cycle pulse: request aborted by lock loss.
- busy  out  1  request in progress.
- locked_sync  out  1  synchronised LOCKED.
- sys_reset  out  1  active-high system reset, synchronous deassert.
- PHASESEL  out  2  to PLL.
- PHASEDIR  out  1  to PLL.
- PHASESTEP  out  1  to PLL, idle high, active low.
- PHASELOADREG  out  1  to PLL, held high.

Behaviour:
- Reset values:
  - state WAIT_LOCK, sys_reset=1, locked_sync=0, both synchroniser flops 0.
  - req_ready=0, busy=0, done=0, err=0.
  - PHASESEL=0, PHASEDIR=0, PHASESTEP=1, PHASELOADREG=1.
  - All counters 0.
- RESET is asynchronous; an assertion mid-step forces the reset values immediately, including PHASESTEP back to 1.
- LOCKED passes through a 2-flop synchroniser; locked_sync is the second flop.
- Per-state rules:
  - WAIT_LOCK: sys_reset=1. If locked_sync=1, go to HOLD with hold counter 0.
  - HOLD: sys_reset=1. The counter increments each cycle with locked_sync=1. locked_sync=0 returns to WAIT_LOCK and clears the counter. When the counter reaches LOCK_STABLE-1 with locked_sync still 1, go to READY; sys_reset is 0 from the first READY cycle.
  - READY: req_ready=1, busy=0. locked_sync=0 goes to WAIT_LOCK, and req_ready drops in that same cycle (combinational on state and locked_sync). A request is accepted when req_valid and req_ready are both high; accepting latches sel, dir and steps.
  - Zero steps: req_steps=0 stays in READY and pulses done the next cycle. No PHASESTEP activity.
  - Nonzero steps: go to SETUP with PHASESEL and PHASEDIR driven from the latched values.
  - SETUP: SETUP_CYC cycles, PHASESTEP=1, then go to PULSE.
  - PULSE: PULSE_CYC cycles, PHASESTEP=0, then go to GAP.
  - GAP: GAP_CYC cycles, PHASESTEP=1, and the remaining-step count decrements on GAP entry. At the end of GAP: remaining>0 goes back to PULSE; remaining=0 goes to READY with done=1 for exactly one cycle, which is the first READY cycle.
- busy=1 in SETUP, PULSE and GAP.
- PHASESEL and PHASEDIR stay stable from SETUP entry through the last GAP cycle, and keep their last value in READY.
- Latency: acceptance edge to done = SETUP_CYC + N*(PULSE_CYC+GAP_CYC) cycles.
- Lock loss (locked_sync=0) in SETUP, PULSE or GAP:
  - Next cycle: PHASESTEP=1, err=1 for one cycle, no done, sys_reset=1, state WAIT_LOCK.
  - The remaining steps are discarded.
- req_valid while not ready: ignored; the requester holds the request until the handshake.
- done and err are never high in the same cycle.
- Counter widths cover their maximum value; req_steps up to 2^STEP_W-1 is supported without wrap.

Test Plan:
- RESET high, LOCKED=1 from t0, RESET released -> sys_reset=1 until exactly 2+1024 cycles after release (±1 for the synchroniser edge); PHASESTEP=1 and PHASELOADREG=1 throughout.
- In HOLD, LOCKED drops for 1 cycle at count 500 -> counter restarts; sys_reset deasserts 1024 cycles after locked_sync returns high.
- In READY, request sel=2, dir=1, steps=3 -> PHASESEL=2 and PHASEDIR=1 from the next cycle; three low pulses of 4 cycles separated by 4 high cycles; done one cycle at 26 cycles after acceptance; busy high in between.
- steps=0 -> done next cycle, no PHASESTEP transition, busy stays 0.
- LOCKED falls during the second PULSE of a 5-step request -> after the 2-cycle sync, PHASESTEP=1 the next cycle, err one cycle, no done, sys_reset=1, req_ready=0 until relock plus 1024 cycles.
- RESET asserted mid-PULSE -> PHASESTEP=1, sys_reset=1, busy=0 asynchronously; a back-to-back request after recovery is accepted normally.
